// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared hazard-unit state encoding, register constants and control bit layout
package cpu_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_LWSTALL = 2'd1,
        HZ_FLUSH   = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CTL_PC_WRITE   = 0;
    localparam int CTL_IFID_WRITE = 1;
    localparam int CTL_LWSTALL    = 2;
    localparam int CTL_BRANCH     = 3;
    localparam int CTL_IF_FLUSH   = 4;
    localparam int CTL_W          = 5;

    localparam logic [CTL_W-1:0] CTL_IDLE  = CTL_W'((1 << CTL_PC_WRITE) | (1 << CTL_IFID_WRITE));
    localparam logic [CTL_W-1:0] CTL_STALL = CTL_W'(1 << CTL_LWSTALL);
    localparam logic [CTL_W-1:0] CTL_FLUSH = CTL_W'((1 << CTL_PC_WRITE) | (1 << CTL_IFID_WRITE) |
                                                    (1 << CTL_BRANCH) | (1 << CTL_IF_FLUSH));
    localparam logic [CTL_W-1:0] CTL_JUMP  = CTL_W'((1 << CTL_PC_WRITE) | (1 << CTL_IFID_WRITE) |
                                                    (1 << CTL_IF_FLUSH));

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side signals seen and driven by the hazard unit
interface hazard_unit_if #(
    parameter int COUNT_W = 16
);
    logic               ID_EX_MemRead;
    logic [4:0]         ID_EX_RegisterRt;
    logic [4:0]         IF_ID_RegisterRs;
    logic [4:0]         IF_ID_RegisterRt;
    logic               IF_ID_uses_rt;
    logic               ID_Jump;
    logic               EX_Branch_taken;
    logic               cnt_clr;
    logic               PC_write;
    logic               IF_ID_write;
    logic               ID_Hazard_lwstall;
    logic               ID_Hazard_Branch;
    logic               IF_Flush;
    logic [COUNT_W-1:0] stall_count;
    logic [COUNT_W-1:0] flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_uses_rt, ID_Jump, EX_Branch_taken, cnt_clr,
        input  PC_write, IF_ID_write, ID_Hazard_lwstall, ID_Hazard_Branch, IF_Flush,
               stall_count, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_uses_rt, ID_Jump, EX_Branch_taken, cnt_clr,
        output PC_write, IF_ID_write, ID_Hazard_lwstall, ID_Hazard_Branch, IF_Flush,
               stall_count, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [COUNT_W-1:0] o_count
);
    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and jump redirect controller
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int LW_STALL_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int COUNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    hazard_unit_if.slave hz
);
    localparam logic [1:0] LW_REM = 2'(LW_STALL_CYCLES - 1);
    localparam logic [1:0] BR_REM = 2'(BR_FLUSH_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        w_next_state;
    logic [1:0]       r_rem;
    logic [1:0]       w_next_rem;
    logic [CTL_W-1:0] w_ctl;
    logic             w_lu;

    assign w_lu = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRt != REG_ZERO) &&
                  ((hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRs) ||
                   (hz.IF_ID_uses_rt && (hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HZ_RUN;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    always_comb begin
        w_ctl        = CTL_IDLE;
        w_next_state = r_state;
        w_next_rem   = r_rem;
        case (r_state)
            HZ_RUN, HZ_LWSTALL: begin
                // A taken branch squashes everything younger, including a stall in progress
                if (hz.EX_Branch_taken) begin
                    w_ctl = CTL_FLUSH;
                    if (BR_FLUSH_CYCLES > 1) begin
                        w_next_state = HZ_FLUSH;
                        w_next_rem   = BR_REM;
                    end else begin
                        w_next_state = HZ_RUN;
                        w_next_rem   = 2'd0;
                    end
                end else if (r_state == HZ_LWSTALL) begin
                    w_ctl      = CTL_STALL;
                    w_next_rem = r_rem - 2'd1;
                    if (r_rem == 2'd1) begin
                        w_next_state = HZ_RUN;
                    end
                end else if (w_lu) begin
                    w_ctl = CTL_STALL;
                    if (LW_STALL_CYCLES > 1) begin
                        w_next_state = HZ_LWSTALL;
                        w_next_rem   = LW_REM;
                    end
                end else if (hz.ID_Jump) begin
                    w_ctl = CTL_JUMP;
                end
            end
            HZ_FLUSH: begin
                w_ctl      = CTL_FLUSH;
                w_next_rem = r_rem - 2'd1;
                if (r_rem == 2'd1) begin
                    w_next_state = HZ_RUN;
                end
            end
            default: begin
                w_next_state = HZ_RUN;
                w_next_rem   = 2'd0;
            end
        endcase
        if (rst) begin
            w_ctl = CTL_IDLE;
        end
    end

    assign hz.PC_write          = w_ctl[CTL_PC_WRITE];
    assign hz.IF_ID_write       = w_ctl[CTL_IFID_WRITE];
    assign hz.ID_Hazard_lwstall = w_ctl[CTL_LWSTALL];
    assign hz.ID_Hazard_Branch  = w_ctl[CTL_BRANCH];
    assign hz.IF_Flush          = w_ctl[CTL_IF_FLUSH];

    sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ctl[CTL_LWSTALL]),
        .i_clr   (hz.cnt_clr),
        .o_count (hz.stall_count)
    );

    sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ctl[CTL_BRANCH]),
        .i_clr   (hz.cnt_clr),
        .o_count (hz.flush_count)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit in two parameterisations
module tb_hazard_unit;
    logic clk;
    logic rst;

    hazard_unit_if #(.COUNT_W(16)) if_a ();
    hazard_unit_if #(.COUNT_W(4))  if_b ();

    hazard_unit #(.LW_STALL_CYCLES(1), .BR_FLUSH_CYCLES(1), .COUNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (if_a)
    );

    hazard_unit #(.LW_STALL_CYCLES(3), .BR_FLUSH_CYCLES(2), .COUNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (if_b)
    );

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       br;
        logic       clr;
    } in_t;

    typedef struct {
        string      name;
        bit         sel;
        logic [4:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    // {IF_Flush, ID_Hazard_Branch, ID_Hazard_lwstall, IF_ID_write, PC_write}
    localparam logic [4:0] E_IDLE  = 5'b00011;
    localparam logic [4:0] E_STALL = 5'b00100;
    localparam logic [4:0] E_FLUSH = 5'b11011;
    localparam logic [4:0] E_JUMP  = 5'b10011;
    localparam bit A = 1'b0;
    localparam bit B = 1'b1;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mk(logic r, logic mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                               logic ur, logic j, logic b, logic c);
        in_t v;
        v.rst = r; v.mr = mr; v.ex_rt = ert; v.rs = rs; v.rt = rt;
        v.uses_rt = ur; v.jump = j; v.br = b; v.clr = c;
        return v;
    endfunction

    task automatic step(input string nm, input bit s, input in_t v,
                        input logic [4:0] ectl, input int esc, input int efc);
        in_t  va;
        in_t  vb;
        exp_t e;
        @(posedge clk);
        #1;
        va = (s == A) ? v : '0;
        vb = (s == B) ? v : '0;
        rst = v.rst;
        if_a.ID_EX_MemRead = va.mr;   if_a.ID_EX_RegisterRt = va.ex_rt;
        if_a.IF_ID_RegisterRs = va.rs; if_a.IF_ID_RegisterRt = va.rt;
        if_a.IF_ID_uses_rt = va.uses_rt; if_a.ID_Jump = va.jump;
        if_a.EX_Branch_taken = va.br;  if_a.cnt_clr = va.clr;
        if_b.ID_EX_MemRead = vb.mr;   if_b.ID_EX_RegisterRt = vb.ex_rt;
        if_b.IF_ID_RegisterRs = vb.rs; if_b.IF_ID_RegisterRt = vb.rt;
        if_b.IF_ID_uses_rt = vb.uses_rt; if_b.ID_Jump = vb.jump;
        if_b.EX_Branch_taken = vb.br;  if_b.cnt_clr = vb.clr;
        e.name = nm; e.sel = s; e.ctl = ectl; e.sc = esc; e.fc = efc;
        exp_q.push_back(e);
    endtask

    // Monitor: the unit presents a control word every cycle; sample mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] act_ctl;
            int         act_sc;
            int         act_fc;
            e = exp_q.pop_front();
            if (e.sel == A) begin
                act_ctl = {if_a.IF_Flush, if_a.ID_Hazard_Branch, if_a.ID_Hazard_lwstall,
                           if_a.IF_ID_write, if_a.PC_write};
                act_sc = int'(if_a.stall_count);
                act_fc = int'(if_a.flush_count);
            end else begin
                act_ctl = {if_b.IF_Flush, if_b.ID_Hazard_Branch, if_b.ID_Hazard_lwstall,
                           if_b.IF_ID_write, if_b.PC_write};
                act_sc = int'(if_b.stall_count);
                act_fc = int'(if_b.flush_count);
            end
            checks++;
            if (act_ctl !== e.ctl || act_sc != e.sc || act_fc != e.fc) begin
                errors++;
                $display("FAIL %s: ctl=%b want %b, stall_count=%0d want %0d, flush_count=%0d want %0d",
                         e.name, act_ctl, e.ctl, act_sc, e.sc, act_fc, e.fc);
            end
        end
    end

    initial begin
        in_t idle;
        in_t lu8;
        idle = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        lu8  = mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
        rst  = 1'b1;
        if_a.ID_EX_MemRead = 0; if_a.ID_EX_RegisterRt = 0; if_a.IF_ID_RegisterRs = 0;
        if_a.IF_ID_RegisterRt = 0; if_a.IF_ID_uses_rt = 0; if_a.ID_Jump = 0;
        if_a.EX_Branch_taken = 0; if_a.cnt_clr = 0;
        if_b.ID_EX_MemRead = 0; if_b.ID_EX_RegisterRt = 0; if_b.IF_ID_RegisterRs = 0;
        if_b.IF_ID_RegisterRt = 0; if_b.IF_ID_uses_rt = 0; if_b.ID_Jump = 0;
        if_b.EX_Branch_taken = 0; if_b.cnt_clr = 0;

        // Configuration A: single-cycle stall and flush, 16-bit counters
        step("a_rst_forced_idle", A, mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0), E_IDLE, 0, 0);
        step("a_idle",            A, idle, E_IDLE, 0, 0);
        step("a_lu_rs",           A, lu8, E_STALL, 0, 0);
        step("a_after_lu",        A, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_IDLE, 1, 0);
        step("a_rt_not_used",     A, mk(0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0), E_IDLE, 1, 0);
        step("a_rt_used",         A, mk(0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0), E_STALL, 1, 0);
        step("a_reg_zero",        A, mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0), E_IDLE, 2, 0);
        step("a_jump",            A, mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), E_JUMP, 2, 0);
        step("a_branch_priority", A, mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0), E_FLUSH, 2, 0);
        step("a_after_branch",    A, idle, E_IDLE, 2, 1);
        step("a_lu_beats_jump",   A, mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0), E_STALL, 2, 1);
        step("a_jump_retry",      A, mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0), E_JUMP, 3, 1);
        step("a_clr_with_stall",  A, mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 1), E_STALL, 3, 1);
        step("a_cleared",         A, idle, E_IDLE, 0, 0);

        // Configuration B: 3-cycle stall, 2-cycle flush, 4-bit counters
        step("b_idle",            B, idle, E_IDLE, 0, 0);
        step("b_lu_c1",           B, lu8, E_STALL, 0, 0);
        step("b_lu_c2",           B, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_STALL, 1, 0);
        step("b_lu_c3",           B, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_STALL, 2, 0);
        step("b_back_to_run",     B, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_IDLE, 3, 0);
        step("b_abort_c1",        B, lu8, E_STALL, 3, 0);
        step("b_abort_branch",    B, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0), E_FLUSH, 4, 0);
        step("b_flush_c2_ignore", B, mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0), E_FLUSH, 4, 1);
        step("b_after_flush",     B, idle, E_IDLE, 4, 2);
        for (int i = 1; i <= 21; i++) begin
            step("b_saturate", B, lu8, E_STALL, ((4 + i - 1) > 15) ? 15 : (4 + i - 1), 2);
        end
        step("b_sat_hold",        B, idle, E_IDLE, 15, 2);
        step("b_rst_stall_c1",    B, lu8, E_STALL, 15, 2);
        step("b_rst_mid_stall",   B, mk(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_IDLE, 0, 0);
        step("b_rst_released",    B, mk(0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0), E_IDLE, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller that produces the stall and flush controls consumed by the PC, the IF_ID register and the ID_EX register (ID_Hazard_lwstall, ID_Hazard_Branch).
- Detects load-use hazards between the instruction in EX and the instruction in ID.
- Handles taken-branch squashing from EX and jump redirects from ID.
- Supports multi-cycle stall and flush windows through a small FSM, and keeps saturating stall and flush event counters for performance debug.

Parameters:
- LW_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3).
- BR_FLUSH_CYCLES, 1, cycles ID_Hazard_Branch and IF_Flush stay high per taken branch (legal 1..3).
- COUNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  5  load destination register.
- IF_ID_RegisterRs  in  5  ID source register Rs.
- IF_ID_RegisterRt  in  5  ID source register Rt.
- IF_ID_uses_rt  in  1  ID instruction reads Rt (R-type, sw, beq).
- ID_Jump  in  1  jump decoded in ID.
- EX_Branch_taken  in  1  branch resolved taken in EX.
- cnt_clr  in  1  synchronous clear of both counters.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF_ID load enable.
- ID_Hazard_lwstall  out  1  ID_EX inserts a bubble.
- ID_Hazard_Branch  out  1  ID_EX flushes to a NOP.
- IF_Flush  out  1  IF_ID flushes to a NOP.
- stall_count  out  COUNT_W  cycles with ID_Hazard_lwstall high.
- flush_count  out  COUNT_W  cycles with ID_Hazard_Branch high.

Behaviour:
- Reset (async, immediate): state=RUN, remaining-cycle counter=0, stall_count=0, flush_count=0.
- While rst is high, outputs are forced idle regardless of inputs: PC_write=1, IF_ID_write=1, ID_Hazard_lwstall=0, ID_Hazard_Branch=0, IF_Flush=0.
- Load-use detect: lu = ID_EX_MemRead & (ID_EX_RegisterRt!=0) & ((ID_EX_RegisterRt==IF_ID_RegisterRs) | (IF_ID_uses_rt & ID_EX_RegisterRt==IF_ID_RegisterRt)).
- Outputs are combinational in the detection cycle, so ID_EX and IF_ID sample them at the same edge. There is zero latency from hazard to control.
- Stall output set: PC_write=0, IF_ID_write=0, ID_Hazard_lwstall=1.
- Flush output set: ID_Hazard_Branch=1, IF_Flush=1, PC_write=1, IF_ID_write=1.
- State RUN:
  - EX_Branch_taken: flush output set. If BR_FLUSH_CYCLES>1, go to FLUSH with rem=BR_FLUSH_CYCLES-1.
  - else lu: stall output set. If LW_STALL_CYCLES>1, go to LWSTALL with rem=LW_STALL_CYCLES-1.
  - else ID_Jump: IF_Flush=1 only; stay RUN.
  - else all idle.
- State LWSTALL: stall output set.
  - Each cycle rem decrements; at rem==1 the FSM returns to RUN at the next edge.
  - The detect is ignored here, because ID_EX_MemRead is already 0 after the first bubble.
- State FLUSH: flush output set.
  - Each cycle rem decrements; at rem==1 the FSM returns to RUN.
- Priority and simultaneous events:
  - A taken branch beats a load-use hazard and beats a jump.
  - EX_Branch_taken while in LWSTALL aborts the stall in that cycle: flush output set, stall outputs deasserted, then FLUSH/RUN as from RUN.
  - A load-use hazard beats a jump: the jump is held in ID and re-evaluated after the stall.
  - In FLUSH, all inputs are ignored.
- Register 0 never creates a hazard.
- Counters:
  - Each counter increments by 1 per cycle its respective output is high.
  - Counters saturate at 2^COUNT_W-1 and never wrap.
  - cnt_clr has priority over increment.
- Reset mid-stall or mid-flush returns to RUN immediately with idle outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams HZ_RUN=2'd0, HZ_LWSTALL=2'd1, HZ_FLUSH=2'd2;
  - REG_ZERO=5'd0;
  - the hazard control bit positions.
- One natural sub-module, sat_counter (COUNT_W; inc, clr, count; async active-high rst). It is instantiated twice.
- The FSM and detect logic stay in hazard_unit.

Test Plan:
- Load-use on Rs, defaults: ID_EX_MemRead=1, ID_EX_RegisterRt=8, IF_ID_RegisterRs=8 → exactly one cycle of PC_write=0, IF_ID_write=0, ID_Hazard_lwstall=1, then idle; stall_count=1.
- Rt compare gating: Rt=9 matches IF_ID_RegisterRt=9 with IF_ID_uses_rt=0 → no stall; with IF_ID_uses_rt=1 → stall. ID_EX_RegisterRt=0 matching Rs=0 → no stall.
- LW_STALL_CYCLES=3, hazard at cycle 5 → ID_Hazard_lwstall high cycles 5,6,7 with ID_EX_MemRead dropped to 0 after cycle 5; RUN at cycle 8; stall_count=3.
- Branch priority: EX_Branch_taken=1 together with lu=1 and ID_Jump=1 → ID_Hazard_Branch=1, IF_Flush=1, ID_Hazard_lwstall=0, PC_write=1. With LW_STALL_CYCLES=3, a taken branch in the 2nd stall cycle aborts the stall in that cycle.
- Jump alone: ID_Jump=1 → IF_Flush=1 for one cycle, ID_Hazard_Branch=0. BR_FLUSH_CYCLES=2 with a taken branch → flush outputs high for 2 cycles; flush_count=2.
- Counters and reset:
  - COUNT_W=4 with 20 stall cycles → stall_count holds at 15.
  - cnt_clr together with a stall → count=0.
  - rst asserted mid-LWSTALL → outputs idle immediately; counters 0; RUN after release.
